layer_sequencer: RTL and testbench

//  Sequences a chain of NUM_LAYERS dense_layer instances for one inference: accepts a sample,

---
 rtl/layer_sequencer_pkg.sv | 22 ++
 rtl/seq_watchdog.sv | 33 +++
 rtl/layer_sequencer.sv | 111 +++++++++++
 tb/tb_layer_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_sequencer_pkg.sv
// Shared types and constants for the dense-layer network and its sequencer.
package layer_sequencer_pkg;

    localparam int unsigned INTEGER_WIDTH       = 8;
    localparam int unsigned FRACTION_WIDTH      = 8;
    localparam int unsigned SEQ_TIMEOUT_DEFAULT = 1024;

    typedef enum logic [1:0] {
        ACT_NONE    = 2'd0,
        ACT_RELU    = 2'd1,
        ACT_SIGMOID = 2'd2
    } activation_type;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_START  = 3'd1,
        SEQ_WAIT   = 3'd2,
        SEQ_OUTPUT = 3'd3,
        SEQ_ERROR  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Per-layer watchdog: counts enabled cycles since the last clear and flags the
// cycle on which the count would reach TIMEOUT_CYCLES.
module seq_watchdog
    import layer_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = SEQ_TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(TIMEOUT_CYCLES))) begin
            count <= count + CW'(1);
        end
    end

    // Asserted one cycle early so the sequencer leaves WAIT on the same edge
    // that the count reaches TIMEOUT_CYCLES.
    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/layer_sequencer.sv
// Control-only sequencer that starts a chain of dense layers one after another
// for each accepted sample, with a per-layer watchdog and inference cycle counter.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int unsigned NUM_LAYERS     = 3,
    parameter int unsigned TIMEOUT_CYCLES = SEQ_TIMEOUT_DEFAULT,
    parameter int unsigned COUNT_WIDTH    = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_LAYERS-1:0]         layer_start,
    input  logic [NUM_LAYERS-1:0]         layer_done,
    output logic                          busy,
    output logic [$clog2(NUM_LAYERS):0]   current_layer,
    output logic                          error,
    input  logic                          error_clear,
    output logic [COUNT_WIDTH-1:0]        cycle_count
);

    localparam int unsigned KW = $clog2(NUM_LAYERS) + 1;

    seq_state_t             state, state_nx;
    logic [KW-1:0]          k;
    logic [NUM_LAYERS-1:0]  done_q, done_q2, rise, sel;
    logic [COUNT_WIDTH-1:0] run_cnt;
    logic                   accept, own_edge, foreign_edge, is_last, wd_expired;

    always_comb begin
        sel         = '0;
        layer_start = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            sel[i]         = (k == KW'(i));
            layer_start[i] = (state == SEQ_START) && (k == KW'(i));
        end
    end

    // Rising edges come from two registered copies, so a level left high by a
    // previous inference never counts as completion.
    assign rise         = done_q & ~done_q2;
    assign own_edge     = |(rise & sel);
    assign foreign_edge = |(rise & ~sel);
    assign is_last      = (k == KW'(NUM_LAYERS - 1));
    assign accept       = in_valid && in_ready;

    always_comb begin
        state_nx = state;
        unique case (state)
            SEQ_IDLE:   if (accept) state_nx = SEQ_START;
            SEQ_START:  state_nx = SEQ_WAIT;
            SEQ_WAIT: begin
                if (foreign_edge)    state_nx = SEQ_ERROR;
                else if (own_edge)   state_nx = is_last ? SEQ_OUTPUT : SEQ_START;
                else if (wd_expired) state_nx = SEQ_ERROR;
            end
            SEQ_OUTPUT: if (out_ready) state_nx = SEQ_IDLE;
            SEQ_ERROR:  if (error_clear) state_nx = SEQ_IDLE;
            default:    state_nx = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= SEQ_IDLE;
            k           <= '0;
            in_ready    <= 1'b0;
            done_q      <= '0;
            done_q2     <= '0;
            run_cnt     <= '0;
            cycle_count <= '0;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx == SEQ_IDLE);
            done_q   <= layer_done;
            done_q2  <= done_q;
            if (accept) begin
                k <= '0;
            end else if ((state == SEQ_WAIT) && (state_nx == SEQ_START)) begin
                k <= k + KW'(1);
            end
            if (accept) begin
                run_cnt <= COUNT_WIDTH'(1);
            end else if ((state != SEQ_IDLE) && (run_cnt != '1)) begin
                run_cnt <= run_cnt + COUNT_WIDTH'(1);
            end
            if ((state == SEQ_WAIT) && (state_nx == SEQ_OUTPUT)) begin
                cycle_count <= run_cnt;
            end
        end
    end

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (state_nx == SEQ_START),
        .enable ((state == SEQ_START) || (state == SEQ_WAIT)),
        .expired(wd_expired)
    );

    assign busy          = (state != SEQ_IDLE);
    assign out_valid     = (state == SEQ_OUTPUT);
    assign error         = (state == SEQ_ERROR);
    assign current_layer = busy ? k : '0;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with three stub layers of programmable delay.
module tb_layer_sequencer;

    localparam int unsigned NL = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          error_clear = 1'b0;
    logic          in_ready, out_valid, busy, error;
    logic [NL-1:0] layer_start, layer_done;
    logic [2:0]    current_layer;
    logic [15:0]   cycle_count;

    logic          s_in_ready, s_out_valid, s_busy, s_error;
    logic [NL-1:0] s_layer_start;
    logic [2:0]    s_current_layer;
    logic [3:0]    s_cycle_count;

    logic [NL-1:0] forced = '0;
    logic [NL-1:0] man = '0;
    logic [NL-1:0] stub_done = '0;
    logic [NL-1:0] active = '0;
    int unsigned   dly [NL] = '{5, 7, 3};
    int unsigned   rem [NL] = '{0, 0, 0};

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    layer_sequencer #(
        .NUM_LAYERS(NL), .TIMEOUT_CYCLES(16), .COUNT_WIDTH(16)
    ) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .layer_start(layer_start),
        .layer_done(layer_done), .busy(busy), .current_layer(current_layer),
        .error(error), .error_clear(error_clear), .cycle_count(cycle_count)
    );

    // Narrow counter copy driven identically; only its saturated count is checked.
    layer_sequencer #(
        .NUM_LAYERS(NL), .TIMEOUT_CYCLES(16), .COUNT_WIDTH(4)
    ) dut_sat (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_ready(out_ready), .layer_start(s_layer_start),
        .layer_done(layer_done), .busy(s_busy), .current_layer(s_current_layer),
        .error(s_error), .error_clear(error_clear), .cycle_count(s_cycle_count)
    );

    assign layer_done = (forced & man) | (~forced & stub_done);

    // Stub layer: drops done on its start pulse, raises it dly cycles later.
    always @(negedge clock) begin
        for (int i = 0; i < NL; i++) begin
            if (layer_start[i]) begin
                stub_done[i] = 1'b0;
                rem[i]       = dly[i];
                active[i]    = 1'b1;
            end else if (active[i]) begin
                rem[i] = rem[i] - 1;
                if (rem[i] == 0) begin
                    stub_done[i] = 1'b1;
                    active[i]    = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_out(input int limit, output int seen);
        seen = 0;
        for (int c = 0; c < limit && seen == 0; c++) begin
            if (out_valid) seen = 1;
            else tick();
        end
    endtask

    initial begin
        int n, out_at, held, seen, got, nst;
        int st_at [3];
        int st_val [3];
        logic [2:0] cl_mid;

        // reset values
        repeat (3) @(posedge clock);
        #1;
        check("rst in_ready", in_ready, 0);
        check("rst busy", busy, 0);
        check("rst out_valid", out_valid, 0);
        check("rst layer_start", layer_start, 0);
        check("rst current_layer", current_layer, 0);
        check("rst error", error, 0);
        check("rst cycle_count", cycle_count, 0);
        reset = 1'b1;
        tick();
        check("in_ready after rst", in_ready, 1);

        // 1: delays 5/7/3
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0; out_at = -1; cl_mid = '1;
        st_at = '{-1, -1, -1};
        st_val = '{0, 0, 0};
        for (int c = 0; c < 60 && out_at < 0; c++) begin
            if (layer_start != 0) begin
                if (n < 3) begin
                    st_at[n]  = c;
                    st_val[n] = layer_start;
                end
                n++;
            end
            if (c == 18) cl_mid = current_layer;
            if (out_valid) out_at = c;
            else tick();
        end
        check("t1 start pulses", n, 3);
        check("t1 start0 at", st_at[0], 0);
        check("t1 start0 val", st_val[0], 1);
        check("t1 start1 at", st_at[1], 7);
        check("t1 start1 val", st_val[1], 2);
        check("t1 start2 at", st_at[2], 16);
        check("t1 start2 val", st_val[2], 4);
        check("t1 current_layer", cl_mid, 2);
        check("t1 out_valid at", out_at, 21);
        check("t1 cycle_count", cycle_count, 21);
        check("t1 saturated count", s_cycle_count, 15);

        // 2: output held without out_ready
        held = 0;
        repeat (10) begin
            tick();
            if (out_valid && !in_ready) held++;
        end
        check("t2 held cycles", held, 10);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2 out_valid after", out_valid, 0);
        check("t2 in_ready after", in_ready, 1);
        check("t2 current_layer idle", current_layer, 0);
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        check("clear in idle busy", busy, 0);
        check("clear in idle in_ready", in_ready, 1);

        // 4: layer 1 never finishes
        forced[1] = 1'b1; man[1] = 1'b0;
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            if (layer_start == 3'b010) seen = 1;
            else tick();
        end
        check("t4 start1 seen", seen, 1);
        n = 0; got = 0;
        for (int c = 1; c <= 40 && got == 0; c++) begin
            tick();
            if (error) begin
                got = 1;
                n = c;
            end
        end
        check("t4 timeout cycles", n, 16);
        check("t4 busy", busy, 1);
        check("t4 in_ready", in_ready, 0);
        check("t4 current_layer", current_layer, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t4 error sticky", error, 1);
        check("t4 no start in error", layer_start, 0);
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        check("t4 error cleared", error, 0);
        check("t4 idle after clear", busy, 0);
        check("t4 in_ready after clear", in_ready, 1);
        check("t4 cycle_count kept", cycle_count, 21);
        forced[1] = 1'b0;
        repeat (2) tick();

        // 3: layer 0 done left high
        forced[0] = 1'b1; man[0] = 1'b1;
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        nst = 0;
        repeat (12) begin
            tick();
            if (layer_start != 0) nst++;
        end
        check("t3 no advance", nst, 0);
        check("t3 still layer 0", current_layer, 0);
        man[0] = 1'b0;
        repeat (2) tick();
        check("t3 fall no advance", current_layer, 0);
        man[0] = 1'b1;
        repeat (2) tick();
        check("t3 edge beats timeout", error, 0);
        check("t3 start1 after edge", layer_start, 3'b010);
        wait_out(40, seen);
        check("t3 out_valid", seen, 1);
        check("t3 cycle_count", cycle_count, 30);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        forced[0] = 1'b0;
        tick();

        // 5: spurious edge, then reset mid-inference
        forced[2] = 1'b1; man[2] = 1'b0;
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        man[2] = 1'b1;
        tick();
        check("t5 no error yet", error, 0);
        tick();
        check("t5 spurious error", error, 1);
        check("t5 current_layer", current_layer, 0);
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        forced[2] = 1'b0;
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        check("t5 busy before reset", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("t5 rst in_ready", in_ready, 0);
        check("t5 rst busy", busy, 0);
        check("t5 rst out_valid", out_valid, 0);
        check("t5 rst layer_start", layer_start, 0);
        check("t5 rst current_layer", current_layer, 0);
        check("t5 rst error", error, 0);
        check("t5 rst cycle_count", cycle_count, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        tick();
        check("t5 in_ready after rst", in_ready, 1);
        repeat (8) tick();

        // 6: back-to-back
        in_valid = 1'b1;
        out_ready = 1'b1;
        wait_out(60, seen);
        check("t6 first out", seen, 1);
        check("t6 first count", cycle_count, 21);
        tick();
        check("t6 bubble in_ready", in_ready, 1);
        check("t6 bubble idle", busy, 0);
        tick();
        check("t6 reaccept start", layer_start, 3'b001);
        check("t6 reaccept in_ready", in_ready, 0);
        in_valid = 1'b0;
        wait_out(60, seen);
        check("t6 second out", seen, 1);
        check("t6 second count", cycle_count, 21);
        tick();
        out_ready = 1'b0;
        check("t6 final idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
